reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Three requesters share one register file write port:
//   0 = ALU, 1 = filter unit, 2 = loader.
// When no burst is active, writes are granted round-robin. The loader can
// also hold the port for a burst of up to MAX_BURST back-to-back writes by
// keeping lock2 high. The write port outputs are registered, so the register
// file writes one cycle after the transfer. The block also flags
// read-after-write hazards for the two read ports of the register file.
//
// Ports
//   clk                  system clock; all state changes on posedge
//   rst                  asynchronous, active-high reset
//   req[2:0]             write request, one bit per requester
//   addr0/1/2 [3:0]      destination register of each requester
//   data0/1/2 [DW-1:0]   write data of each requester
//   lock2                loader asks to keep the port (burst)
//   gnt[2:0]             combinational grant, one-hot or zero
//   wr_addr[3:0]         register file write address (registered)
//   wr_data[DW-1:0]      register file write data (registered)
//   wr_we_n              register file write enable, active low (registered)
//   rd_addr_a/b[3:0]     register file read addresses
//   hazard_a/b           read address matches a pending or in-flight write
//
// FSM states
//   state | meaning
//   ARB   | round-robin arbitration among all requesters
//   BURST | loader owns the port; only gnt[2] can assert
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [3:0]    addr0,
    input  logic [3:0]    addr1,
    input  logic [3:0]    addr2,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic          lock2,
    output logic [2:0]    gnt,
    output logic [3:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_we_n,
    input  logic [3:0]    rd_addr_a,
    input  logic [3:0]    rd_addr_b,
    output logic          hazard_a,
    output logic          hazard_b
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] cnt_inc;
    // High for exactly the first ARB cycle after a burst hit MAX_BURST.
    logic          rel, rel_nxt;

    logic [2:0]    elig;
    logic          excl2;
    logic [2:0]    gnt_arb;
    logic          xfer;
    logic [1:0]    win;
    logic [3:0]    sel_addr;
    logic [DW-1:0] sel_data;

    // Round-robin pick: search ptr+1, ptr+2, ptr (mod 3). A forced release
    // keeps the loader out if anyone else is waiting.
    always_comb begin
        gnt_arb = 3'b000;
        excl2   = rel && (req[0] || req[1]);
        elig    = req & {~excl2, 2'b11};
        case (ptr)
            2'd0: begin
                if (elig[1])      gnt_arb = 3'b010;
                else if (elig[2]) gnt_arb = 3'b100;
                else if (elig[0]) gnt_arb = 3'b001;
            end
            2'd1: begin
                if (elig[2])      gnt_arb = 3'b100;
                else if (elig[0]) gnt_arb = 3'b001;
                else if (elig[1]) gnt_arb = 3'b010;
            end
            default: begin
                if (elig[0])      gnt_arb = 3'b001;
                else if (elig[1]) gnt_arb = 3'b010;
                else if (elig[2]) gnt_arb = 3'b100;
            end
        endcase
    end

    // In BURST the loader is granted only while it still holds lock2; the
    // cycle it drops lock2 is the release cycle and carries no transfer.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            if (state == BURST) gnt = {req[2] & lock2, 2'b00};
            else                gnt = gnt_arb;
        end
    end

    assign xfer = |gnt;

    always_comb begin
        win = 2'd0;
        if (gnt[2])      win = 2'd2;
        else if (gnt[1]) win = 2'd1;
    end

    always_comb begin
        sel_addr = addr0;
        sel_data = data0;
        case (win)
            2'd1: begin
                sel_addr = addr1;
                sel_data = data1;
            end
            2'd2: begin
                sel_addr = addr2;
                sel_data = data2;
            end
            default: begin
                sel_addr = addr0;
                sel_data = data0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        rel_nxt   = 1'b0;
        cnt_inc   = cnt + CW'(1);
        case (state)
            ARB: begin
                if (xfer) begin
                    ptr_nxt = win;
                    if (gnt[2] && lock2) begin
                        state_nxt = BURST;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            BURST: begin
                if (!lock2 || (gnt[2] && cnt_inc == CNT_MAX)) begin
                    state_nxt = ARB;
                    cnt_nxt   = '0;
                    ptr_nxt   = 2'd2;
                    rel_nxt   = gnt[2] && (cnt_inc == CNT_MAX);
                end else if (gnt[2]) begin
                    cnt_nxt = cnt_inc;
                    ptr_nxt = 2'd2;
                end
            end
            default: begin
                state_nxt = ARB;
                cnt_nxt   = '0;
                ptr_nxt   = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            ptr   <= 2'd2;
            cnt   <= '0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            rel   <= rel_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_we_n <= 1'b1;
            wr_addr <= 4'd0;
            wr_data <= '0;
        end else if (xfer) begin
            wr_we_n <= 1'b0;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_we_n <= 1'b1;
        end
    end

    // A read collides with the write already on the port or with any write
    // still waiting for a grant.
    always_comb begin
        hazard_a = (!wr_we_n && (rd_addr_a == wr_addr))
                || (req[0] && (rd_addr_a == addr0))
                || (req[1] && (rd_addr_a == addr1))
                || (req[2] && (rd_addr_a == addr2));
        hazard_b = (!wr_we_n && (rd_addr_b == wr_addr))
                || (req[0] && (rd_addr_b == addr0))
                || (req[1] && (rd_addr_b == addr1))
                || (req[2] && (rd_addr_b == addr2));
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [3:0]    addr0, addr1, addr2;
    logic [DW-1:0] data0, data1, data2;
    logic          lock2;
    logic [2:0]    gnt;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_we_n;
    logic [3:0]    rd_addr_a, rd_addr_b;
    logic          hazard_a, hazard_b;

    reg_write_arbiter #(.DW(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .lock2(lock2), .gnt(gnt),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_we_n(wr_we_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the loader either owns the port (with a beat count)
    // or everyone takes turns after the last winner.
    bit            m_burst;
    int            m_beats;
    int            m_last;
    bit            m_rel;
    logic          exp_we_n;
    logic [3:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic [2:0]    obs_gnt;
    logic          obs_ha;

    task automatic model_reset();
        m_burst  = 0;
        m_beats  = 0;
        m_last   = 2;
        m_rel    = 0;
        exp_we_n = 1'b1;
        exp_addr = 4'd0;
        exp_data = '0;
    endtask

    function automatic logic [2:0] model_gnt();
        int c;
        if (m_burst) return {req[2] & lock2, 2'b00};
        for (int k = 1; k <= 3; k++) begin
            c = (m_last + k) % 3;
            if (req[c] && !(c == 2 && m_rel && (req[0] || req[1])))
                return 3'(1 << c);
        end
        return 3'b000;
    endfunction

    function automatic logic model_hz(input logic [3:0] rd);
        return (!exp_we_n && rd == exp_addr) || (req[0] && addr0 == rd)
            || (req[1] && addr1 == rd) || (req[2] && addr2 == rd);
    endfunction

    task automatic model_update(input logic [2:0] g);
        int t;
        bit rel_n;
        t = -1;
        rel_n = 0;
        for (int i = 0; i < 3; i++) if (g[i]) t = i;
        if (t >= 0) begin
            exp_we_n = 1'b0;
            exp_addr = (t == 0) ? addr0 : (t == 1) ? addr1 : addr2;
            exp_data = (t == 0) ? data0 : (t == 1) ? data1 : data2;
        end else begin
            exp_we_n = 1'b1;
        end
        if (!m_burst) begin
            if (t >= 0) m_last = t;
            if (t == 2 && lock2) begin
                m_burst = 1;
                m_beats = 1;
            end
        end else begin
            if (t == 2) m_beats++;
            if (!lock2 || m_beats == MAXB) begin
                rel_n   = (t == 2 && m_beats == MAXB);
                m_burst = 0;
                m_beats = 0;
                m_last  = 2;
            end
        end
        m_rel = rel_n;
    endtask

    // One clock cycle: inputs are already driven; check mid-cycle, then
    // advance the model past the posedge.
    task automatic cyc();
        logic [2:0] g;
        #3;
        g = model_gnt();
        check_val("gnt", 64'(gnt), 64'(g));
        check_val("wr_we_n", 64'(wr_we_n), 64'(exp_we_n));
        if (!exp_we_n) begin
            check_val("wr_addr", 64'(wr_addr), 64'(exp_addr));
            check_val("wr_data", 64'(wr_data), 64'(exp_data));
        end
        check_val("hazard_a", 64'(hazard_a), 64'(model_hz(rd_addr_a)));
        check_val("hazard_b", 64'(hazard_b), 64'(model_hz(rd_addr_b)));
        obs_gnt = gnt;
        obs_ha  = hazard_a;
        @(posedge clk);
        #1;
        model_update(g);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_gnt", 64'(gnt), 64'd0);
        check_val("rst_we_n", 64'(wr_we_n), 64'd1);
        check_val("rst_addr", 64'(wr_addr), 64'd0);
        check_val("rst_data", 64'(wr_data), 64'd0);
        repeat (hold) @(posedge clk);
        #1;
        check_val("rst_hold_gnt", 64'(gnt), 64'd0);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [2:0] r, input logic l);
        req   = r;
        lock2 = l;
        addr0 = 4'($urandom_range(0, 15));
        addr1 = 4'($urandom_range(0, 15));
        addr2 = 4'($urandom_range(0, 15));
        data0 = $urandom;
        data1 = $urandom;
        data2 = $urandom;
    endtask

    logic [2:0] rr_exp [6];
    logic [2:0] bst_exp [7];

    initial begin
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bst_exp = '{3'b001, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd14;
        drive(3'b111, 1'b0);
        do_reset(2);

        // Round-robin with everyone requesting.
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 1'b0);
            cyc();
            check_val("rr_order", 64'(obs_gnt), 64'(rr_exp[i]));
        end

        // Capped burst, then forced release to the ALU.
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            drive(3'b101, 1'b1);
            cyc();
            check_val("burst_seq", 64'(obs_gnt), 64'(bst_exp[i]));
        end

        // Early release after two beats.
        do_reset(1);
        for (int i = 0; i < 2; i++) begin
            drive(3'b100, 1'b1);
            cyc();
            check_val("early_beat", 64'(obs_gnt), 64'(3'b100));
        end
        drive(3'b110, 1'b0);
        cyc();
        check_val("release_cyc", 64'(obs_gnt), 64'(3'b000));
        cyc();
        check_val("after_release", 64'(obs_gnt), 64'(3'b010));

        // Hazard on a pending and then in-flight write.
        do_reset(1);
        drive(3'b010, 1'b0);
        addr1 = 4'd5;
        rd_addr_a = 4'd5;
        cyc();
        check_val("hz_pending", 64'(obs_ha), 64'd1);
        drive(3'b000, 1'b0);
        cyc();
        check_val("hz_inflight", 64'(obs_ha), 64'd1);
        cyc();
        check_val("hz_clear", 64'(obs_ha), 64'd0);

        // Reset in the middle of a burst.
        do_reset(1);
        for (int i = 0; i < 2; i++) begin
            drive(3'b100, 1'b1);
            cyc();
        end
        do_reset(1);
        drive(3'b111, 1'b0);
        cyc();
        check_val("post_rst_gnt", 64'(obs_gnt), 64'(3'b001));

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            drive(3'($urandom_range(0, 7)) | {($urandom_range(0, 3) != 0), 2'b00},
                  ($urandom_range(0, 3) != 0));
            rd_addr_a = 4'($urandom_range(0, 15));
            rd_addr_b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
